// File: rtl/l2_way_select_if.sv
// l2_way_select_if
// Bundles the lookup request, registered response and PLRU commit signals
// between the L2 controller / tag comparator (master) and l2_way_select (slave).
//   lookup_valid/ready, lookup_index, hit_vec, valid_vec : lookup request
//   resp_valid/ready, resp_hit, resp_way, multi_hit      : registered response
//   commit, commit_index, commit_way                     : PLRU update
interface l2_way_select_if #(
    parameter int unsigned index_width = 1
);
    logic                   lookup_valid;
    logic                   lookup_ready;
    logic [index_width-1:0] lookup_index;
    logic [7:0]             hit_vec;
    logic [7:0]             valid_vec;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_hit;
    logic [2:0]             resp_way;
    logic                   multi_hit;
    logic                   commit;
    logic [index_width-1:0] commit_index;
    logic [2:0]             commit_way;

    modport master (
        output lookup_valid, lookup_index, hit_vec, valid_vec,
        output resp_ready, commit, commit_index, commit_way,
        input  lookup_ready, resp_valid, resp_hit, resp_way, multi_hit
    );

    modport slave (
        input  lookup_valid, lookup_index, hit_vec, valid_vec,
        input  resp_ready, commit, commit_index, commit_way,
        output lookup_ready, resp_valid, resp_hit, resp_way, multi_hit
    );
endinterface

// File: rtl/l2_way_select.sv
// l2_way_select
// Way resolution and replacement for the 8-way L2. Qualifies the tag match
// vector with the set's valid bits and returns a registered hit/miss, way
// (hit way or victim way) and sticky multi-hit flag. Holds a 7-bit tree PLRU
// per set, updated only through the commit port.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : l2_way_select_if slave (lookup, response, commit)
module l2_way_select #(
    parameter int unsigned index_width = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    l2_way_select_if.slave  bus
);
    localparam int unsigned NUM_SETS = 1 << index_width;

    logic       resp_valid_q, resp_valid_d;
    logic       resp_hit_q,   resp_hit_d;
    logic [2:0] resp_way_q,   resp_way_d;
    logic       multi_hit_q,  multi_hit_d;
    logic [6:0] plru_q [NUM_SETS];
    logic [6:0] plru_d [NUM_SETS];

    logic       accept;
    logic [7:0] qual;
    logic       any_hit;
    logic       many_hit;
    logic [2:0] hit_way;
    logic       any_invalid;
    logic [2:0] invalid_way;
    logic [6:0] lk_plru;
    logic [2:0] plru_way;
    logic [6:0] upd;
    logic [3:0] upd_pair;
    logic [3:0] lk_pair;

    assign bus.lookup_ready = !resp_valid_q || bus.resp_ready;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_way     = resp_way_q;
    assign bus.multi_hit    = multi_hit_q;

    assign accept = bus.lookup_valid && bus.lookup_ready;

    // PLRU next state; the lookup below reads plru_d so a same-cycle commit
    // to the looked-up set is already reflected in the victim.
    always_comb begin
        for (int unsigned s = 0; s < NUM_SETS; s++) begin
            plru_d[s] = plru_q[s];
        end
        upd      = plru_q[bus.commit_index];
        upd[0]   = !bus.commit_way[2];
        if (bus.commit_way[2]) begin
            upd[2] = !bus.commit_way[1];
        end else begin
            upd[1] = !bus.commit_way[1];
        end
        upd_pair = upd[6:3];
        upd_pair[bus.commit_way[2:1]] = !bus.commit_way[0];
        upd[6:3] = upd_pair;
        if (bus.commit) begin
            plru_d[bus.commit_index] = upd;
        end
    end

    // Lowest qualified match, multi-match detect, lowest invalid way.
    always_comb begin
        qual        = bus.hit_vec & bus.valid_vec;
        any_hit     = |qual;
        many_hit    = |(qual & (qual - 8'd1));
        hit_way     = '0;
        any_invalid = ~&bus.valid_vec;
        invalid_way = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (qual[i-1]) begin
                hit_way = 3'(i - 1);
            end
            if (!bus.valid_vec[i-1]) begin
                invalid_way = 3'(i - 1);
            end
        end
    end

    // Tree walk: root picks the half, p[1]/p[2] the quad, p[3..6] the way.
    always_comb begin
        lk_plru     = plru_d[bus.lookup_index];
        lk_pair     = lk_plru[6:3];
        plru_way[2] = lk_plru[0];
        plru_way[1] = lk_plru[0] ? lk_plru[2] : lk_plru[1];
        plru_way[0] = lk_pair[plru_way[2:1]];
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        multi_hit_d  = multi_hit_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_hit_d   = any_hit;
            multi_hit_d  = multi_hit_q || many_hit;
            if (any_hit) begin
                resp_way_d = hit_way;
            end else if (any_invalid) begin
                resp_way_d = invalid_way;
            end else begin
                resp_way_d = plru_way;
            end
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            multi_hit_q  <= 1'b0;
            plru_q       <= '{default: '0};
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
            multi_hit_q  <= multi_hit_d;
            plru_q       <= plru_d;
        end
    end
endmodule

// File: tb/tb_l2_way_select.sv
module tb_l2_way_select;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    l2_way_select_if #(.index_width(1)) bus ();

    l2_way_select #(.index_width(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:0] idx;
        logic [7:0] hit;
        logic [7:0] vld;
        logic       exp_hit;
        logic [2:0] exp_way;
        logic       exp_multi;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lookup_valid = 1'b0;
        bus.lookup_index = '0;
        bus.hit_vec      = '0;
        bus.valid_vec    = '0;
        bus.resp_ready   = 1'b1;
        bus.commit       = 1'b0;
        bus.commit_index = '0;
        bus.commit_way   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic commit_way(input logic [0:0] idx, input logic [2:0] w);
        bus.commit       = 1'b1;
        bus.commit_index = idx;
        bus.commit_way   = w;
        step();
        bus.commit       = 1'b0;
    endtask

    // Single-cycle full-set miss lookup; returns the registered victim.
    task automatic miss_lookup(input logic [0:0] idx, input string name, input logic [2:0] exp_way);
        bus.lookup_valid = 1'b1;
        bus.lookup_index = idx;
        bus.hit_vec      = 8'h00;
        bus.valid_vec    = 8'hFF;
        step();
        bus.lookup_valid = 1'b0;
        chk({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({name, "_hit"}, 32'(bus.resp_hit), 32'd0);
        chk({name, "_way"}, 32'(bus.resp_way), 32'(exp_way));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        // idx, hit, valid, exp_hit, exp_way, exp_multi (PLRU all zero)
        vecs[0] = '{1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0};
        vecs[1] = '{1'b0, 8'h24, 8'h20, 1'b1, 3'd5, 1'b0};
        vecs[2] = '{1'b1, 8'hFF, 8'h01, 1'b1, 3'd0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 8'hEF, 1'b0, 3'd4, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'hFF, 1'b1, 3'd7, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[6] = '{1'b1, 8'h00, 8'h7F, 1'b0, 3'd7, 1'b0};
        vecs[7] = '{1'b0, 8'h24, 8'h24, 1'b1, 3'd2, 1'b1};
        vecs[8] = '{1'b0, 8'h10, 8'hFF, 1'b1, 3'd4, 1'b1};

        do_reset();
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_hit", 32'(bus.resp_hit), 32'd0);
        chk("rst_way", 32'(bus.resp_way), 32'd0);
        chk("rst_multi", 32'(bus.multi_hit), 32'd0);
        chk("rst_ready", 32'(bus.lookup_ready), 32'd1);

        // Back-to-back table vectors with resp_ready held high.
        for (int i = 0; i < 9; i++) begin
            bus.lookup_valid = 1'b1;
            bus.lookup_index = vecs[i].idx;
            bus.hit_vec      = vecs[i].hit;
            bus.valid_vec    = vecs[i].vld;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bus.resp_valid), 32'd1);
            chk($sformatf("vec%0d_hit", i), 32'(bus.resp_hit), 32'(vecs[i].exp_hit));
            chk($sformatf("vec%0d_way", i), 32'(bus.resp_way), 32'(vecs[i].exp_way));
            chk($sformatf("vec%0d_multi", i), 32'(bus.multi_hit), 32'(vecs[i].exp_multi));
        end
        bus.lookup_valid = 1'b0;
        step();
        chk("drain_valid", 32'(bus.resp_valid), 32'd0);
        chk("drain_multi_sticky", 32'(bus.multi_hit), 32'd1);

        // Commit sequence on index 1; expected victims from walking the tree.
        do_reset();
        chk("rst2_multi", 32'(bus.multi_hit), 32'd0);
        for (int w = 0; w < 4; w++) commit_way(1'b1, 3'(w));
        miss_lookup(1'b1, "plru_c0to3", 3'd4);
        for (int w = 4; w < 7; w++) commit_way(1'b1, 3'(w));
        miss_lookup(1'b1, "plru_c0to6", 3'd0);
        commit_way(1'b1, 3'd7);
        miss_lookup(1'b1, "plru_c7", 3'd0);
        commit_way(1'b1, 3'd2);
        miss_lookup(1'b1, "plru_c2", 3'd4);
        miss_lookup(1'b0, "plru_idx0", 3'd0);

        // Same-cycle commit and lookup of the same set: bypass.
        do_reset();
        bus.commit       = 1'b1;
        bus.commit_index = 1'b1;
        bus.commit_way   = 3'd0;
        miss_lookup(1'b1, "bypass", 3'd4);
        bus.commit = 1'b0;
        miss_lookup(1'b1, "bypass_array", 3'd4);
        miss_lookup(1'b0, "bypass_idx0", 3'd0);

        // Backpressure: response held, no new accept.
        do_reset();
        bus.lookup_valid = 1'b1;
        bus.lookup_index = 1'b0;
        bus.hit_vec      = 8'h80;
        bus.valid_vec    = 8'hFF;
        bus.resp_ready   = 1'b0;
        step();
        chk("bp_accept_valid", 32'(bus.resp_valid), 32'd1);
        chk("bp_ready_low", 32'(bus.lookup_ready), 32'd0);
        bus.hit_vec   = 8'h03;
        bus.valid_vec = 8'h03;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                bus.commit       = 1'b1;
                bus.commit_index = 1'b1;
                bus.commit_way   = 3'd0;
            end else begin
                bus.commit = 1'b0;
            end
            step();
            chk($sformatf("bp%0d_valid", c), 32'(bus.resp_valid), 32'd1);
            chk($sformatf("bp%0d_hit", c), 32'(bus.resp_hit), 32'd1);
            chk($sformatf("bp%0d_way", c), 32'(bus.resp_way), 32'd7);
            chk($sformatf("bp%0d_multi", c), 32'(bus.multi_hit), 32'd0);
            chk($sformatf("bp%0d_ready", c), 32'(bus.lookup_ready), 32'd0);
        end
        // Commit made while stalled must have reached the array.
        bus.lookup_valid = 1'b0;
        bus.resp_ready   = 1'b1;
        step();
        chk("bp_release", 32'(bus.resp_valid), 32'd0);
        miss_lookup(1'b1, "bp_commit_seen", 3'd4);

        // Reset while a response is pending; same-edge commit is ignored.
        commit_way(1'b1, 3'd2);
        bus.lookup_valid = 1'b1;
        bus.hit_vec      = 8'h03;
        bus.valid_vec    = 8'h03;
        bus.resp_ready   = 1'b0;
        step();
        chk("pend_valid", 32'(bus.resp_valid), 32'd1);
        chk("pend_multi", 32'(bus.multi_hit), 32'd1);
        reset_n          = 1'b0;
        bus.commit       = 1'b1;
        bus.commit_index = 1'b1;
        bus.commit_way   = 3'd0;
        step();
        chk("prst_valid", 32'(bus.resp_valid), 32'd0);
        chk("prst_hit", 32'(bus.resp_hit), 32'd0);
        chk("prst_way", 32'(bus.resp_way), 32'd0);
        chk("prst_multi", 32'(bus.multi_hit), 32'd0);
        chk("prst_ready", 32'(bus.lookup_ready), 32'd1);
        reset_n          = 1'b1;
        bus.commit       = 1'b0;
        bus.lookup_valid = 1'b0;
        bus.resp_ready   = 1'b1;
        miss_lookup(1'b1, "prst_plru1", 3'd0);
        miss_lookup(1'b0, "prst_plru0", 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
